// File: rtl/cuckoo_time_ctrl.sv
// Time-of-day controller for the cuckoo clock: BCD hh:mm:ss in 12-hour format,
// hour/minute set modes driven by button pulses, and the top-of-hour strike sequencer.
module cuckoo_time_ctrl #(
    parameter int unsigned CHIRP_LEN = 4,
    parameter int unsigned CHIRP_GAP = 4
) (
    input  logic       clk,
    input  logic       not_reset,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [2:0] sec_t,
    output logic [3:0] sec_o,
    output logic [2:0] min_t,
    output logic [3:0] min_o,
    output logic       hr_t,
    output logic [3:0] hr_o,
    output logic [1:0] mode,
    output logic       cuckoo,
    output logic       cuckoo_busy
);

    typedef enum logic [1:0] {
        ModeRun    = 2'd0,
        ModeSetHr  = 2'd1,
        ModeSetMin = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StOn   = 2'd1,
        StGap  = 2'd2
    } strike_e;

    localparam int unsigned MaxCnt = (CHIRP_LEN > CHIRP_GAP) ? CHIRP_LEN : CHIRP_GAP;
    localparam int unsigned TimerW = (MaxCnt > 1) ? $clog2(MaxCnt) : 1;
    localparam logic [TimerW-1:0] LenLoad = TimerW'(CHIRP_LEN - 1);
    localparam logic [TimerW-1:0] GapLoad = TimerW'(CHIRP_GAP - 1);

    mode_e             mode_q, mode_d;
    logic [6:0]        sec_q, sec_d;
    logic [6:0]        min_q, min_d;
    logic [4:0]        hr_q, hr_d;
    strike_e           strike_q, strike_d;
    logic [3:0]        remain_q, remain_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic              cuckoo_q, cuckoo_d;
    logic              busy_q, busy_d;

    logic       run_tick;
    logic       trigger;
    logic       abort;
    logic [3:0] hr_bin;

    // Packed BCD {tens, ones} increment over 00..59.
    function automatic logic [6:0] inc_b60(input logic [6:0] v);
        if (v[3:0] == 4'd9) begin
            return (v[6:4] == 3'd5) ? 7'h00 : {v[6:4] + 3'd1, 4'd0};
        end
        return {v[6:4], v[3:0] + 4'd1};
    endfunction

    // Packed BCD hour increment over 01..12.
    function automatic logic [4:0] inc_hr(input logic [4:0] v);
        if (v == 5'h12) begin
            return 5'h01;
        end
        if (v[3:0] == 4'd9) begin
            return 5'h10;
        end
        return {v[4], v[3:0] + 4'd1};
    endfunction

    assign run_tick = (mode_q == ModeRun) && !btn_mode && tick_1hz;
    assign trigger  = run_tick && (sec_q == 7'h59) && (min_q == 7'h59);
    assign abort    = btn_mode && (mode_q == ModeRun);
    assign hr_bin   = hr_d[4] ? (4'd10 + hr_d[3:0]) : hr_d[3:0];

    // Mode and time-of-day next state; btn_mode suppresses inc and tick in the same cycle.
    always_comb begin
        mode_d = mode_q;
        sec_d  = sec_q;
        min_d  = min_q;
        hr_d   = hr_q;
        if (btn_mode) begin
            unique case (mode_q)
                ModeRun: begin
                    mode_d = ModeSetHr;
                    sec_d  = 7'h00;
                end
                ModeSetHr:  mode_d = ModeSetMin;
                default:    mode_d = ModeRun;
            endcase
        end else begin
            unique case (mode_q)
                ModeRun: begin
                    if (tick_1hz) begin
                        sec_d = inc_b60(sec_q);
                        if (sec_q == 7'h59) begin
                            min_d = inc_b60(min_q);
                            if (min_q == 7'h59) begin
                                hr_d = inc_hr(hr_q);
                            end
                        end
                    end
                end
                ModeSetHr: begin
                    if (btn_inc) begin
                        hr_d = inc_hr(hr_q);
                    end
                end
                default: begin
                    if (btn_inc) begin
                        min_d = inc_b60(min_q);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge not_reset) begin
        if (!not_reset) begin
            mode_q <= ModeRun;
            sec_q  <= 7'h00;
            min_q  <= 7'h00;
            hr_q   <= 5'h12;
        end else begin
            mode_q <= mode_d;
            sec_q  <= sec_d;
            min_q  <= min_d;
            hr_q   <= hr_d;
        end
    end

    // Strike FSM: state register.
    always_ff @(posedge clk or negedge not_reset) begin
        if (!not_reset) begin
            strike_q <= StIdle;
            remain_q <= 4'd0;
            timer_q  <= '0;
            cuckoo_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            strike_q <= strike_d;
            remain_q <= remain_d;
            timer_q  <= timer_d;
            cuckoo_q <= cuckoo_d;
            busy_q   <= busy_d;
        end
    end

    // Strike FSM: next state. Abort wins over trigger, trigger restarts a running strike.
    always_comb begin
        strike_d = strike_q;
        remain_d = remain_q;
        timer_d  = timer_q;
        if (abort) begin
            strike_d = StIdle;
            remain_d = 4'd0;
            timer_d  = '0;
        end else if (trigger) begin
            strike_d = StOn;
            remain_d = hr_bin;
            timer_d  = LenLoad;
        end else begin
            unique case (strike_q)
                StOn: begin
                    if (timer_q == '0) begin
                        remain_d = remain_q - 4'd1;
                        if (remain_q == 4'd1) begin
                            strike_d = StIdle;
                        end else begin
                            strike_d = StGap;
                            timer_d  = GapLoad;
                        end
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
                StGap: begin
                    if (timer_q == '0) begin
                        strike_d = StOn;
                        timer_d  = LenLoad;
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
                default: strike_d = StIdle;
            endcase
        end
    end

    // Strike FSM: outputs, registered from the next state so they move with it.
    always_comb begin
        cuckoo_d = (strike_d == StOn);
        busy_d   = (strike_d != StIdle);
    end

    assign sec_t       = sec_q[6:4];
    assign sec_o       = sec_q[3:0];
    assign min_t       = min_q[6:4];
    assign min_o       = min_q[3:0];
    assign hr_t        = hr_q[4];
    assign hr_o        = hr_q[3:0];
    assign mode        = mode_q;
    assign cuckoo      = cuckoo_q;
    assign cuckoo_busy = busy_q;

endmodule

// File: tb/tb_cuckoo_time_ctrl.sv
// Directed bench for cuckoo_time_ctrl: rollovers with strikes, set modes, abort,
// coincident pulses and asynchronous reset.
module tb_cuckoo_time_ctrl;

    logic       clk;
    logic       not_reset;
    logic       tick_1hz;
    logic       btn_mode;
    logic       btn_inc;
    logic [2:0] sec_t;
    logic [3:0] sec_o;
    logic [2:0] min_t;
    logic [3:0] min_o;
    logic       hr_t;
    logic [3:0] hr_o;
    logic [1:0] mode;
    logic       cuckoo;
    logic       cuckoo_busy;

    int tests_run;
    int tests_failed;

    cuckoo_time_ctrl #(
        .CHIRP_LEN(4),
        .CHIRP_GAP(4)
    ) dut (
        .clk        (clk),
        .not_reset  (not_reset),
        .tick_1hz   (tick_1hz),
        .btn_mode   (btn_mode),
        .btn_inc    (btn_inc),
        .sec_t      (sec_t),
        .sec_o      (sec_o),
        .min_t      (min_t),
        .min_o      (min_o),
        .hr_t       (hr_t),
        .hr_o       (hr_o),
        .mode       (mode),
        .cuckoo     (cuckoo),
        .cuckoo_busy(cuckoo_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        tests_run++;
        if (obs != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Displayed time as decimal hhmmss.
    function automatic int now_time();
        return (int'(hr_t) * 10 + int'(hr_o)) * 10000
             + (int'(min_t) * 10 + int'(min_o)) * 100
             + int'(sec_t) * 10 + int'(sec_o);
    endfunction

    // All stimulus tasks start and end at a falling edge.
    task automatic pulse(input logic m, input logic i, input logic t);
        btn_mode = m;
        btn_inc  = i;
        tick_1hz = t;
        @(negedge clk);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        tick_1hz = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) pulse(1'b0, 1'b0, 1'b1);
    endtask

    task automatic incs(input int n);
        for (int k = 0; k < n; k++) pulse(1'b0, 1'b1, 1'b0);
    endtask

    // Samples from the current falling edge until busy drops (bounded).
    task automatic measure_strike(output int hi, output int busy, output int chirps);
        logic prev;
        prev   = 1'b0;
        hi     = 0;
        busy   = 0;
        chirps = 0;
        for (int k = 0; k < 300; k++) begin
            if (cuckoo) hi++;
            if (cuckoo && !prev) chirps++;
            prev = cuckoo;
            if (!cuckoo_busy) break;
            busy++;
            @(negedge clk);
        end
    endtask

    task automatic idle_window(input string tag, input int n);
        int seen;
        seen = 0;
        for (int k = 0; k < n; k++) begin
            if (cuckoo || cuckoo_busy) seen++;
            @(negedge clk);
        end
        check(tag, seen, 0);
    endtask

    int hi, busy, chirps;

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        not_reset    = 1'b0;
        tick_1hz     = 1'b0;
        btn_mode     = 1'b0;
        btn_inc      = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset_time", now_time(), 120000);
        check("reset_mode", int'(mode), 0);
        check("reset_cuckoo", int'(cuckoo), 0);
        check("reset_busy", int'(cuckoo_busy), 0);
        not_reset = 1'b1;
        idle_window("no_strike_after_reset", 10);

        // 12:59:59 -> 01:00:00, one chirp
        pulse(1'b1, 1'b0, 1'b0);
        check("mode_sethr", int'(mode), 1);
        pulse(1'b1, 1'b0, 1'b0);
        check("mode_setmin", int'(mode), 2);
        incs(59);
        check("set_1259", now_time(), 125900);
        pulse(1'b1, 1'b0, 1'b0);
        check("mode_run", int'(mode), 0);
        ticks(59);
        check("time_125959", now_time(), 125959);
        ticks(1);
        check("time_010000", now_time(), 10000);
        check("cuckoo_on_rollover", int'(cuckoo), 1);
        measure_strike(hi, busy, chirps);
        check("strike1_high", hi, 4);
        check("strike1_busy", busy, 4);
        check("strike1_chirps", chirps, 1);
        idle_window("strike1_idle", 10);

        // 11:59:59 -> 12:00:00, twelve chirps
        pulse(1'b1, 1'b0, 1'b0);
        incs(10);
        check("set_hr_11", now_time(), 110000);
        pulse(1'b1, 1'b0, 1'b0);
        incs(59);
        pulse(1'b1, 1'b0, 1'b0);
        ticks(59);
        check("time_115959", now_time(), 115959);
        ticks(1);
        check("time_120000", now_time(), 120000);
        measure_strike(hi, busy, chirps);
        check("strike12_high", hi, 48);
        check("strike12_busy", busy, 92);
        check("strike12_chirps", chirps, 12);

        // Set modes from 12:34:56
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, 1'b0);
        incs(34);
        pulse(1'b1, 1'b0, 1'b0);
        ticks(56);
        check("time_123456", now_time(), 123456);
        pulse(1'b1, 1'b0, 1'b0);
        check("sethr_clears_sec", now_time(), 123400);
        check("sethr_mode", int'(mode), 1);
        incs(1);
        check("hr_wrap_12_01", now_time(), 13400);
        pulse(1'b1, 1'b0, 1'b0);
        incs(25);
        check("min_59", now_time(), 15900);
        incs(1);
        check("min_wrap_no_carry", now_time(), 10000);
        ticks(3);
        check("ticks_frozen_setmin", now_time(), 10000);
        pulse(1'b1, 1'b0, 1'b0);
        check("back_to_run", int'(mode), 0);
        ticks(5);
        check("time_010005", now_time(), 10005);

        // Coincident pulses
        pulse(1'b1, 1'b0, 1'b1);
        check("mode_tick_mode", int'(mode), 1);
        check("mode_tick_time", now_time(), 10000);
        ticks(2);
        check("ticks_frozen_sethr", now_time(), 10000);
        pulse(1'b1, 1'b1, 1'b0);
        check("mode_inc_mode", int'(mode), 2);
        check("mode_inc_time", now_time(), 10000);
        pulse(1'b1, 1'b0, 1'b0);

        // Abort during the 3rd chirp of a 5-chirp strike
        pulse(1'b1, 1'b0, 1'b0);
        incs(3);
        pulse(1'b1, 1'b0, 1'b0);
        incs(59);
        pulse(1'b1, 1'b0, 1'b0);
        ticks(60);
        check("time_050000", now_time(), 50000);
        repeat (17) @(negedge clk);
        check("chirp3_cuckoo", int'(cuckoo), 1);
        check("chirp3_busy", int'(cuckoo_busy), 1);
        pulse(1'b1, 1'b0, 1'b0);
        check("abort_cuckoo", int'(cuckoo), 0);
        check("abort_busy", int'(cuckoo_busy), 0);
        check("abort_mode", int'(mode), 1);
        idle_window("abort_idle", 20);

        // Asynchronous reset mid-strike
        pulse(1'b1, 1'b0, 1'b0);
        incs(59);
        pulse(1'b1, 1'b0, 1'b0);
        ticks(60);
        check("time_060000", now_time(), 60000);
        check("strike6_on", int'(cuckoo), 1);
        repeat (3) @(negedge clk);
        #2 not_reset = 1'b0;
        #1;
        check("midreset_cuckoo", int'(cuckoo), 0);
        check("midreset_busy", int'(cuckoo_busy), 0);
        check("midreset_time", now_time(), 120000);
        check("midreset_mode", int'(mode), 0);
        @(negedge clk);
        not_reset = 1'b1;
        idle_window("midreset_idle", 40);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
